// File: rtl/demux_pkg.sv
// Shared constants, FSM encoding and round-robin search for the 1x4 demux
// feeder and its downstream collector.
package demux_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Searches cur+1 .. cur+4 (mod NCH); the descending loop leaves the
    // nearest enabled channel as the final winner. Returns cur if nothing else is enabled.
    function automatic logic [SELW-1:0] next_enabled(input logic [SELW-1:0] cur,
                                                     input logic [NCH-1:0]  en);
        logic [SELW-1:0] idx;
        next_enabled = cur;
        for (int k = NCH; k >= 1; k--) begin
            idx = cur + SELW'(k);
            if (en[idx]) next_enabled = idx;
        end
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational next-enabled-channel search, shared with the downstream collector.
module rr_next_sel
    import demux_pkg::*;
(
    input  logic [SELW-1:0] cur,
    input  logic [NCH-1:0]  en,
    output logic [SELW-1:0] nxt,
    output logic            any
);

    assign nxt = next_enabled(cur, en);
    assign any = |en;

endmodule

// File: rtl/demux_rr_dispatcher.sv
// Round-robin valid/ready feeder for the 1x4 demux: one-deep registered output
// stage driving select A and Y_data, with bursts, enable skipping and backpressure.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int W     = 1,
    parameter int BURST = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NCH-1:0]  en,
    input  logic [NCH-1:0]  out_ready,
    output logic [SELW-1:0] A,
    output logic [W-1:0]    Y_data,
    output logic            out_valid,
    output logic            busy
);

    state_e          state;
    logic [7:0]      bcnt;
    logic [SELW-1:0] nxt;
    logic            any_en;
    logic            fire;
    logic            accept;
    logic            last;
    logic            retarget;

    rr_next_sel u_sel (
        .cur (A),
        .en  (en),
        .nxt (nxt),
        .any (any_en)
    );

    assign out_valid = (state == HOLD);
    assign busy      = out_valid;
    assign fire      = out_valid & out_ready[A];
    assign in_ready  = any_en & (!out_valid | fire);
    assign accept    = in_valid & in_ready;
    assign last      = (bcnt == 8'(BURST - 1));
    // Pointer sits on a disabled channel: move off it, whether empty or holding.
    assign retarget  = !fire & any_en & !en[A];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            A      <= '0;
            Y_data <= '0;
            bcnt   <= '0;
        end else begin
            if (fire) begin
                if (last) begin
                    bcnt <= '0;
                    A    <= nxt;
                end else begin
                    bcnt <= bcnt + 8'd1;
                end
            end else if (retarget) begin
                bcnt <= '0;
                A    <= nxt;
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= HOLD;
                        Y_data <= in_data;
                    end
                end
                HOLD: begin
                    if (fire) begin
                        if (accept) Y_data <= in_data;
                        else        state  <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher with a fire-time scoreboard per instance.
module tb_demux_rr_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_data1, in_valid1, in_ready1, ov1, busy1, y1;
    logic [3:0] en1, out_ready1;
    logic [1:0] a1;

    logic [3:0] in_data3, y3, en3, out_ready3;
    logic       in_valid3, in_ready3, ov3, busy3;
    logic [1:0] a3;

    int checks = 0;
    int errors = 0;
    int waits;

    logic [5:0] sb1[$];
    logic [5:0] sb3[$];
    logic [5:0] e1, e3;

    always #5 clk = ~clk;

    demux_rr_dispatcher #(.W(1), .BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .en(en1), .out_ready(out_ready1), .A(a1),
        .Y_data(y1), .out_valid(ov1), .busy(busy1)
    );

    demux_rr_dispatcher #(.W(4), .BURST(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .en(en3), .out_ready(out_ready3), .A(a3),
        .Y_data(y3), .out_valid(ov3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every fire pops the oldest expected {A, data}.
    always @(negedge clk) begin
        if (rst_n && ov1 && out_ready1[a1]) begin
            chk("sb1_unexpected_fire", sb1.size() > 0, 1);
            if (sb1.size() > 0) begin
                e1 = sb1.pop_front();
                chk("sb1_A", a1, e1[5:4]);
                chk("sb1_Y", y1, e1[3:0]);
            end
            chk("busy1", busy1, ov1);
        end
        if (rst_n && ov3 && out_ready3[a3]) begin
            chk("sb3_unexpected_fire", sb3.size() > 0, 1);
            if (sb3.size() > 0) begin
                e3 = sb3.pop_front();
                chk("sb3_A", a3, e3[5:4]);
                chk("sb3_Y", y3, e3[3:0]);
            end
        end
    end

    task automatic send(input int sel, input logic [3:0] d, input logic [1:0] ea, output int w);
        logic rdy;
        w = 0;
        if (sel == 1) begin
            in_valid1 = 1'b1; in_data1 = d[0]; sb1.push_back({ea, 3'b000, d[0]});
        end else begin
            in_valid3 = 1'b1; in_data3 = d;    sb3.push_back({ea, d});
        end
        rdy = 1'b0;
        while (!rdy && w <= 50) begin
            @(negedge clk);
            rdy = (sel == 1) ? in_ready1 : in_ready3;
            if (!rdy) w++;
        end
        chk("accept_timeout", rdy, 1);
        @(posedge clk);
        #1;
        if (sel == 1) in_valid1 = 1'b0; else in_valid3 = 1'b0;
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while (((sel == 1) ? sb1.size() : sb3.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", n < 100, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid1 = 0; in_data1 = 0; en1 = 0; out_ready1 = 0;
        in_valid3 = 0; in_data3 = 0; en3 = 0; out_ready3 = 0;
        #2;
        chk("rst_ov1", ov1, 0);
        chk("rst_a1", a1, 0);
        chk("rst_y1", y1, 0);
        chk("rst_inrdy1", in_ready1, 0);
        chk("rst_ov3", ov3, 0);
        chk("rst_a3", a3, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ov1", ov1, 0);

        // 1: full enable, BURST=1, back-to-back stream
        en1 = 4'b1111; out_ready1 = 4'b1111;
        send(1, 4'd1, 2'd0, waits); chk("t1_wait0", waits, 0);
        send(1, 4'd0, 2'd1, waits); chk("t1_wait1", waits, 0);
        send(1, 4'd1, 2'd2, waits); chk("t1_wait2", waits, 0);
        send(1, 4'd1, 2'd3, waits); chk("t1_wait3", waits, 0);
        drain(1);
        chk("t1_a_wrap", a1, 0);

        // 2: only channels 1 and 3
        en1 = 4'b1010;
        send(1, 4'd1, 2'd1, waits);
        send(1, 4'd0, 2'd3, waits);
        send(1, 4'd0, 2'd1, waits);
        send(1, 4'd1, 2'd3, waits);
        drain(1);
        chk("t2_a_end", a1, 1);

        // 3: BURST=3 instance
        en3 = 4'b1111; out_ready3 = 4'b1111;
        send(3, 4'h3, 2'd0, waits);
        send(3, 4'hA, 2'd0, waits);
        send(3, 4'h5, 2'd0, waits);
        send(3, 4'hF, 2'd1, waits);
        send(3, 4'h0, 2'd1, waits);
        send(3, 4'h9, 2'd1, waits);
        send(3, 4'h6, 2'd2, waits);
        drain(3);
        chk("t3_a_end", a3, 2);
        chk("t3_ov_end", ov3, 0);

        // 4: backpressure on held item
        en1 = 4'b1111; out_ready1 = 4'b0000;
        send(1, 4'd1, 2'd1, waits);
        repeat (5) begin
            @(negedge clk);
            chk("t4_ov", ov1, 1);
            chk("t4_a", a1, 1);
            chk("t4_y", y1, 1);
            chk("t4_inrdy", in_ready1, 0);
        end
        @(posedge clk); #1;
        out_ready1 = 4'b1111;
        @(negedge clk);
        chk("t4_inrdy_fire", in_ready1, 1);
        @(posedge clk); #1;
        chk("t4_ov_after", ov1, 0);
        chk("t4_a_after", a1, 2);

        // 5: enable drop while holding on channel 2
        out_ready1 = 4'b0000;
        send(1, 4'd0, 2'd3, waits);
        @(negedge clk);
        chk("t5_a_held", a1, 2);
        chk("t5_ov_held", ov1, 1);
        @(posedge clk); #1;
        en1 = 4'b1000;
        @(posedge clk); #1;
        chk("t5_a_retarget", a1, 3);
        chk("t5_y_kept", y1, 0);
        chk("t5_ov_kept", ov1, 1);
        out_ready1 = 4'b1111;
        drain(1);
        chk("t5_a_stay", a1, 3);
        // en=0 with an item held
        out_ready1 = 4'b0000;
        send(1, 4'd1, 2'd3, waits);
        en1 = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            chk("t5_en0_inrdy", in_ready1, 0);
            chk("t5_en0_a", a1, 3);
            chk("t5_en0_ov", ov1, 1);
            chk("t5_en0_y", y1, 1);
        end
        @(posedge clk); #1;
        en1 = 4'b1000; out_ready1 = 4'b1111;
        drain(1);

        // 6: asynchronous reset mid-HOLD
        en1 = 4'b1111; out_ready1 = 4'b0000;
        send(1, 4'd1, 2'd3, waits);
        @(negedge clk);
        chk("t6_ov_pre", ov1, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ov", ov1, 0);
        chk("t6_rst_a", a1, 0);
        chk("t6_rst_y", y1, 0);
        if (sb1.size() > 0) void'(sb1.pop_front());
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_pulse", ov1, 0);
        out_ready1 = 4'b1111;
        send(1, 4'd1, 2'd0, waits);
        drain(1);

        chk("sb1_left", sb1.size(), 0);
        chk("sb3_left", sb3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
- Upstream feeder for the 1x4 demultiplexer: accepts a valid/ready data stream and hands each item to one of four channels in round-robin order.
- Drives the demux select (A) and the data bit/word (Y_data) from registered state, so the demux sees glitch-free, cycle-stable inputs.
- Skips disabled channels, honours per-channel backpressure, and supports bursts of BURST items per channel before advancing.

Parameters:
W, 1, data width of the stream and of Y_data.
BURST, 1, items sent to one channel before the pointer advances; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_data  input  W  upstream data.
in_valid  input  1  upstream item present.
in_ready  output  1  dispatcher accepts in_data this cycle.
en  input  4  channel enable mask; bit i enables channel i.
out_ready  input  4  per-channel consumer ready; only out_ready[A] is used.
A  output  2  channel select into the demux.
Y_data  output  W  data into the demux In.
out_valid  output  1  Y_data is valid for channel A.
busy  output  1  equals out_valid.

Behaviour:
- Reset, asynchronous while rst_n=0: A=0, Y_data=0, out_valid=0, burst count=0. in_ready is combinational and evaluates to 0 while en=0.
- States:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; one item is buffered in the output register.
- Definitions:
  - fire = out_valid & out_ready[A].
  - accept = in_valid & in_ready.
- in_ready = (en != 0) & (!out_valid | fire). This allows one item per cycle at full throughput.
- Transitions:
  - EMPTY→HOLD on accept.
  - HOLD→HOLD on fire & accept.
  - HOLD→EMPTY on fire & !accept.
  - HOLD stays on !fire.
- Latency: an item accepted at edge t is visible on Y_data with out_valid=1 from edge t until it fires. There is no bypass path.
- Burst counter:
  - Increments on each fire.
  - When it reaches BURST-1 on a fire, it clears and A advances to the next enabled channel, searching A+1, A+2, A+3, A+4 mod 4.
  - If only the current channel is enabled, A stays put.
- Pointer in EMPTY: if en[A]=0 and en!=0, A moves to the next enabled channel on the next edge and the burst count clears.
- Enable drop while in HOLD (en[A] falls with out_valid=1, no fire): the held item is not dropped. Next edge: A retargets to the next enabled channel and the burst count clears. The item then fires on the new channel.
- en=0 entirely: in_ready=0, A frozen, and any held item stays held until some channel is re-enabled.
- Simultaneous fire and advance with accept: the new item is presented on the advanced A in the following cycle.
- Stability: A and Y_data change only at clock edges and only when fire occurs, on accept into EMPTY, or on a retarget. While out_valid=1 and no fire, Y_data is held.
- Wrap-around: channel 3 advances to 0. The burst counter wraps to 0 at BURST-1.
- Reset mid-HOLD discards the held item. No output pulses on reset release.

Decomposition:
- Shared package demux_pkg:
  - NCH=4.
  - Select width constant SELW=2.
  - Function next_enabled(cur[1:0], en[3:0]) returning the next enabled index in round-robin order (cur if none other is enabled).
- One natural sub-module: rr_next_sel, a combinational next-enabled-channel search. It is reusable by the downstream collector.
- Remaining logic (FSM, burst counter, output register) stays in the top module.
- The existing 1x4 demux is instantiated by the integrator, not inside this block.

Test Plan:
1. Reset, en=4'b1111, out_ready=4'b1111, BURST=1; stream bits 1,0,1,1 back-to-back → A sequence 0,1,2,3, one item per cycle, in_ready held 1.
2. en=4'b1010, BURST=1; stream 4 items → A visits 1,3,1,3 and never selects 0 or 2.
3. BURST=3, en=4'b1111; 7 items, all ready → A=0 for 3 fires, A=1 for 3, then A=2 for 1.
4. out_ready[A]=0 for 5 cycles with an item held → Y_data and A stable, in_ready=0; ready restored → fire on the next edge and in_ready=1 in that cycle.
5. Item held on A=2, en[2] cleared, en[3] set → next edge A=3, same Y_data, fires on channel 3; en=0 then → in_ready=0, A frozen.
6. Assert rst_n=0 mid-HOLD, asynchronously between edges → out_valid=0, A=0, Y_data=0 immediately; after release, the first accepted item goes to channel 0.
